// File: rtl/mult_prod_accum_pkg.sv
// Shared types and defaults for the product accumulator and its saturating adder.
// The count width helper sizes term_cnt so it can hold the value NUM_TERMS itself.
package mult_prod_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int DEF_PROD_W    = 48;
    localparam int DEF_ACC_W     = 56;
    localparam int DEF_NUM_TERMS = 16;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_prod_accum_sat_add.sv
// Unsigned saturating adder: sums at W+1 bits and clamps to all-ones on carry-out.
// Purely combinational; ovf flags that the clamp was applied.
module sat_add_u #(
    parameter int W = 56
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] wide_sum;

    assign wide_sum = {1'b0, a} + {1'b0, b};
    assign ovf      = wide_sum[W];
    assign sum      = wide_sum[W] ? {W{1'b1}} : wide_sum[W-1:0];

endmodule

// File: rtl/mult_prod_accum.sv
// Accumulates NUM_TERMS unsigned products into a saturating accumulator and
// offers the sum on a valid/ready port; clear aborts the run in progress.
module mult_prod_accum
    import mult_prod_accum_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int NUM_TERMS = DEF_NUM_TERMS
) (
    input  logic                             clock0,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [PROD_W-1:0]                in_prod,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_W-1:0]                 out_data,
    output logic                             out_ovf,
    output logic [$clog2(NUM_TERMS+1)-1:0]   term_cnt,
    output logic                             busy
);

    localparam int               CNT_W    = cnt_width(NUM_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sticky_q, sticky_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic               beat;
    logic               take;

    assign prod_ext = ACC_W'(in_prod);

    // acc_q is zero in IDLE, so the first beat goes through the same adder path.
    sat_add_u #(
        .W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign term_cnt  = cnt_q;

    assign beat = in_valid && in_ready;
    assign take = out_valid && out_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (clear) begin
                    state_d  = ST_IDLE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end else if (beat) begin
                    acc_d    = add_sum;
                    cnt_d    = cnt_q + CNT_W'(1);
                    sticky_d = sticky_q | add_ovf;
                    if (cnt_q == LAST_CNT) begin
                        state_d    = ST_HOLD;
                        out_data_d = add_sum;
                        out_ovf_d  = sticky_q | add_ovf;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                // clear and take both end the hold; out_data/out_ovf keep the last result.
                if (clear || take) begin
                    state_d  = ST_IDLE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: doc/mult_prod_accum.md
Name: mult_prod_accum

Overview:
- Downstream consumer of the registered-output unsigned multiplier chain (28x20 -> 48-bit product).
- Accumulates a fixed number of unsigned 48-bit products into a wide accumulator, then presents the sum on a valid/ready output port.
- Provides a saturating add, a sticky overflow flag and a synchronous abort.
- Intended use: dot-product / MAC benchmarks fed by the multiplier chain.

Parameters:
- PROD_W, 48, width of incoming product (matches multiplier output).
- ACC_W, 56, accumulator/result width; must be >= PROD_W.
- NUM_TERMS, 16, products summed per result; must be >= 1.

Ports:
- clock0  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous abort of the current accumulation.
- in_valid  in  1  product beat valid. The upstream multiplier's 1-cycle register latency is already aligned by the upstream stage.
- in_prod  in  PROD_W  unsigned product, zero-extended to ACC_W.
- in_ready  out  1  block can accept a beat.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  accumulated sum.
- out_ovf  out  1  result saturated.
- term_cnt  out  $clog2(NUM_TERMS+1)  beats accepted in the current accumulation.
- busy  out  1  high in ACCUM or HOLD.

Behaviour:
- Reset: "reset, synchronous, active-high; clock clock0."
  - All state cleared: state=IDLE, acc=0, term_cnt=0, out_valid=0, out_data=0, out_ovf=0, busy=0.
  - in_ready=1 in the first cycle after reset deasserts.
- Priority: reset > clear > normal operation.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is taken when out_valid && out_ready.
  - in_ready = (state != HOLD); it is combinational from state only.
- States:
  - IDLE: term_cnt=0, acc=0. An accepted beat sets acc <= in_prod and term_cnt <= 1. Next state is ACCUM, or HOLD if NUM_TERMS==1.
  - ACCUM: each accepted beat sets acc <= sat(acc + in_prod) and term_cnt <= term_cnt+1.
    - On the NUM_TERMS-th beat: out_data <= final sum, out_ovf <= sticky flag OR this beat's overflow, out_valid <= 1 (next cycle), next state HOLD.
    - Cycles without in_valid leave all state unchanged.
  - HOLD:
    - out_valid=1; out_data and out_ovf held stable until taken; in_ready=0.
    - On out_ready: next cycle out_valid=0, acc=0, term_cnt=0, sticky cleared, state=IDLE.
    - No beat is accepted in the take cycle.
- Latency: out_valid rises 1 cycle after the final beat is accepted. Minimum result period is NUM_TERMS+1 cycles.
- Arithmetic:
  - Unsigned; in_prod is zero-extended to ACC_W.
  - The sum is computed at ACC_W+1 bits. If the carry-out is set, acc <= all-ones and the sticky overflow is set.
  - Once saturated, acc stays all-ones until the result is taken.
- clear:
  - In IDLE or ACCUM: acc, term_cnt and sticky are zeroed and state goes to IDLE. Any beat presented in that cycle is dropped.
  - In HOLD: out_valid drops and the pending result is discarded. A simultaneous out_ready is ignored.
- out_data and out_ovf retain the last result after it is taken. They are only updated on HOLD entry.
- busy = (state != IDLE).

Decomposition:
- Package mult_prod_accum_pkg:
  - State enum {IDLE, ACCUM, HOLD}.
  - Default PROD_W, ACC_W and NUM_TERMS constants.
  - Count-width function.
- One sub-module, sat_add_u: parameterised ACC_W unsigned saturating adder. It is combinational, with outputs sum and ovf.
- FSM, counter and output register stay in the top module.

Test Plan:
- Basic sum: 16 beats of 0xFFFF_FFFF_FFFF back-to-back, out_ready=1 -> out_valid pulses 1 cycle after the 16th beat; out_data=0xF_FFFF_FFFF_FFF0; out_ovf=0; in_ready high again 2 cycles after the last beat.
- Gaps and backpressure:
  - Beats 1..16, each of value 3, with in_valid toggling every cycle -> out_data=48.
  - Then hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 throughout, out_data stays 48, the next result equals the sum of the 16 beats after the take (no lost or duplicated beats).
- Saturation: ACC_W=48, NUM_TERMS=2; beats 0x8000_0000_0000 and 0x8000_0000_0001 -> out_data=0xFFFF_FFFF_FFFF, out_ovf=1. The next result from beats 1 and 2 -> out_data=3, out_ovf=0.
- Clear mid-operation: 7 beats of value 5, then clear together with in_valid (value 9), then 16 beats of value 1 -> out_data=16; term_cnt is 0 the cycle after clear.
- Reset in HOLD: result pending with out_ready=0; assert reset 1 cycle -> out_valid=0, out_data=0, term_cnt=0, in_ready=1 the following cycle.
- NUM_TERMS=1: beats 10, 20, 30 with out_ready=1 -> three results 10, 20, 30; in_ready pattern 1,0,1,0,1.
